// File: rtl/lm07_pkg.sv
// lm07_pkg: shared state encoding and frame geometry for the LM07/LM70
// read sequencer.
package lm07_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        DONE,
        GAP
    } lm07_state_e;

    localparam int LM07_FRAME_BITS = 16;
    localparam int LM07_TEMP_MSB   = 15;
    localparam int LM07_TEMP_LSB   = 5;
    localparam int LM07_TEMP_W     = 11;

endpackage

// File: rtl/lm07_interval_timer.sv
// lm07_interval_timer: free-running interval counter that emits a one-cycle
// tick every 'interval' enabled cycles. Any change of 'interval' restarts the
// count from zero; interval == 0 or en == 0 freezes it.
module lm07_interval_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] interval,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] ival_q;

    // Next count and tick; a changed interval takes priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (interval != ival_q) begin
            cnt_d = '0;
        end else if (en && (interval != '0)) begin
            if (cnt_q == interval - PERIOD_W'(1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    // Counter and last-seen interval registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            ival_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ival_q <= interval;
        end
    end

endmodule

// File: rtl/lm07_read_sched.sv
// lm07_read_sched: SPI read sequencer for the LM07/LM70 temperature sensor.
// Merges periodic and single-shot read demands, clocks out one 16-bit frame
// per cs_n window and presents it on a valid/ready output with a sticky
// overrun flag.
// Build option: define LM07_AVG4_EN to make temp_q the running mean of the
// last four loaded temperatures instead of the raw frame field.
module lm07_read_sched
    import lm07_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_IDLE  = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [PERIOD_W-1:0]    interval,
    input  logic                   req,
    output logic                   busy,
    output logic                   cs_n,
    output logic                   sck,
    input  logic                   sio,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic [15:0]            sample_data,
    output logic [LM07_TEMP_W-1:0] temp_q,
    output logic                   overrun,
    input  logic                   clr_overrun
);

    localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                             ((CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE) :
                             ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_IDLE - 1);

    lm07_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [3:0]                 bit_cnt_q, bit_cnt_d;
    logic [LM07_FRAME_BITS-1:0] shift_q, shift_d;
    logic                       pending_q, pending_d;
    logic                       cs_n_q, cs_n_d;
    logic                       sck_q, sck_d;
    logic                       valid_q, valid_d;
    logic [LM07_FRAME_BITS-1:0] data_q, data_d;
    logic                       ovr_q, ovr_d;
    logic                       tick;
    logic                       start;
    logic                       load;

    lm07_interval_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .interval (interval),
        .tick     (tick)
    );

    // Transfer sequencing: state, phase counter, bit counter, pins, shifter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        start     = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q && en) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = SCK_HI;
                    sck_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCK_HI: begin
                // Sensor drives on the falling edge, so sio is settled by
                // the end of the high phase.
                if (cnt_q == DIV_LAST) begin
                    shift_d = {shift_q[LM07_FRAME_BITS-2:0], sio};
                    state_d = SCK_LO;
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCK_LO: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (bit_cnt_q < 4'd15) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = SCK_HI;
                        sck_d     = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cs_n_d    = 1'b1;
                load      = 1'b1;
                bit_cnt_d = '0;
                cnt_d     = '0;
                state_d   = GAP;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Demand merging and the output slot: a new demand always wins over the
    // start-of-transfer clear, and a set of overrun wins over its clear.
    always_comb begin
        pending_d = (pending_q && !start) || req || tick;
        valid_d   = valid_q;
        data_d    = data_q;
        ovr_d     = ovr_q;
        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            if (valid_q && !sample_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            pending_q <= 1'b0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            pending_q <= pending_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ovr_q     <= ovr_d;
        end
    end

    // Shift register; every frame fully overwrites it, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign busy         = (state_q != IDLE) && (state_q != GAP);
    assign cs_n         = cs_n_q;
    assign sck          = sck_q;
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign overrun      = ovr_q;

`ifdef LM07_AVG4_EN
    logic signed [LM07_TEMP_W-1:0] hist_q [4];
    logic signed [LM07_TEMP_W-1:0] hist_d [4];
    logic signed [LM07_TEMP_W-1:0] avg_q, avg_d;
    logic signed [LM07_TEMP_W-1:0] new_temp;
    logic                          primed_q, primed_d;

    // Mean of four: 13-bit signed sum, arithmetic shift right by two.
    function automatic logic signed [LM07_TEMP_W-1:0] mean4(
        input logic signed [LM07_TEMP_W-1:0] a,
        input logic signed [LM07_TEMP_W-1:0] b,
        input logic signed [LM07_TEMP_W-1:0] c,
        input logic signed [LM07_TEMP_W-1:0] d
    );
        logic signed [LM07_TEMP_W+1:0] sum;
        logic signed [LM07_TEMP_W+1:0] shifted;
        sum = $signed({{2{a[LM07_TEMP_W-1]}}, a}) + $signed({{2{b[LM07_TEMP_W-1]}}, b}) +
              $signed({{2{c[LM07_TEMP_W-1]}}, c}) + $signed({{2{d[LM07_TEMP_W-1]}}, d});
        shifted = sum >>> 2;
        return shifted[LM07_TEMP_W-1:0];
    endfunction

    assign new_temp = $signed(shift_q[LM07_TEMP_MSB:LM07_TEMP_LSB]);

    // History update on each load; the first load fills all four slots.
    always_comb begin
        hist_d   = hist_q;
        avg_d    = avg_q;
        primed_d = primed_q;
        if (load) begin
            if (!primed_q) begin
                hist_d[0] = new_temp;
                hist_d[1] = new_temp;
                hist_d[2] = new_temp;
                hist_d[3] = new_temp;
            end else begin
                hist_d[0] = new_temp;
                hist_d[1] = hist_q[0];
                hist_d[2] = hist_q[1];
                hist_d[3] = hist_q[2];
            end
            primed_d = 1'b1;
            avg_d    = mean4(hist_d[0], hist_d[1], hist_d[2], hist_d[3]);
        end
    end

    // History and averaged-output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            avg_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            avg_q    <= avg_d;
            primed_q <= primed_d;
        end
    end

    assign temp_q = avg_q;
`else
    assign temp_q = data_q[LM07_TEMP_MSB:LM07_TEMP_LSB];
`endif

endmodule

// File: tb/tb_lm07_read_sched.sv
// tb_lm07_read_sched: sensor pin model plus scoreboard for lm07_read_sched.
`timescale 1ns/1ps
module tb_lm07_read_sched;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_IDLE  = 8;
    localparam int PERIOD_W = 16;
    localparam int XFER_LEN = CS_SETUP + 32 * CLK_DIV + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b1;
    logic [PERIOD_W-1:0] interval = '0;
    logic                req = 1'b0;
    logic                sample_ready = 1'b0;
    logic                clr_overrun = 1'b0;
    logic                sio;
    logic                busy, cs_n, sck, sample_valid, overrun;
    logic [15:0]         sample_data;
    logic [10:0]         temp_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lm07_read_sched #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_IDLE  (CS_IDLE),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .interval     (interval),
        .req          (req),
        .busy         (busy),
        .cs_n         (cs_n),
        .sck          (sck),
        .sio          (sio),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .temp_q       (temp_q),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] data;
        logic [10:0] temp;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_ovr = 1'b0;
`ifdef LM07_AVG4_EN
    int   hist[$];
`endif

    // Expected temp_q after a frame is loaded into the output.
    function automatic logic [10:0] model_load(input logic [15:0] frame);
        int t;
        t = $signed(frame[15:5]);
`ifdef LM07_AVG4_EN
        if (hist.size() == 0) begin
            repeat (4) hist.push_front(t);
        end else begin
            hist.push_front(t);
            void'(hist.pop_back());
        end
        t = (hist[0] + hist[1] + hist[2] + hist[3]) >>> 2;
`endif
        return 11'(t);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_ovr = 1'b0;
`ifdef LM07_AVG4_EN
        hist.delete();
`endif
    endtask

    // ---------------- sensor pin model ----------------
    logic [15:0] preset    = 16'h041F;
    logic [15:0] cur_frame = '0;
    bit          rand_frames = 1'b0;
    int          bit_idx  = -1;
    int          rises    = 0;
    int          cyc      = 0;
    int          fall_cyc = 0;
    int          rise_cyc = 0;
    int          n_falls  = 0;
    int          fall_log[$];

    assign sio = (bit_idx >= 0 && bit_idx < 16) ? cur_frame[bit_idx[3:0]] : 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge cs_n) begin
        if (rand_frames) preset = 16'($urandom);
        cur_frame = preset;
        bit_idx   = 15;
        rises     = 0;
        fall_cyc  = cyc;
        n_falls++;
        fall_log.push_back(cyc);
    end

    always @(posedge sck) if (cs_n === 1'b0) rises++;
    always @(negedge sck) if (cs_n === 1'b0) bit_idx--;

    // End of a cs_n window: verify its shape and record the expected output.
    always @(posedge cs_n) begin
        exp_t e;
        if (rst !== 1'b1) begin
            check("sck_rises", rises, 16);
            check("cs_low_len", cyc - fall_cyc, XFER_LEN);
            rise_cyc = cyc;
            e.data = cur_frame;
            e.temp = model_load(cur_frame);
            if (exp_q.size() != 0) begin
                exp_q[0] = e;
                exp_ovr  = 1'b1;
            end else begin
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            check("valid_vs_model", sample_valid, exp_q.size() != 0);
            if (sample_valid && sample_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sample_data", sample_data, e.data);
                check("temp_q", temp_q, e.temp);
                check("overrun", overrun, exp_ovr);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_cs(input logic level, input int budget, input string name);
        int n;
        n = 0;
        while (cs_n !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, cs_n, level);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        int n;
        step(3);
        // Reset values
        check("rst_cs_n", cs_n, 1);
        check("rst_sck", sck, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_temp", temp_q, 0);
        rst = 1'b0;
        step(2);

        // 1: single req, frame 0x041F
        preset = 16'h041F;
        pulse_req();
        wait_cs(1'b0, 10, "t1_start");
        check("t1_busy", busy, 1);
        wait_cs(1'b1, 200, "t1_end");
        check("t1_valid", sample_valid, 1);
        check("t1_data", sample_data, 16'h041F);
        check("t1_temp", temp_q, 32);
        sample_ready = 1'b1;
        step(2);
        check("t1_consumed", sample_valid, 0);

        // 2: periodic reads every 300 cycles
        preset = 16'h101F;
        fall_log.delete();
        interval = 16'd300;
        for (int k = 0; k < 4; k++) begin
            wait_cs(1'b0, 400, "t2_fall");
            wait_cs(1'b1, 200, "t2_rise");
            check("t2_temp", temp_q, 128);
        end
        check("t2_nfalls", fall_log.size(), 4);
        for (int k = 1; k < fall_log.size(); k++)
            check("t2_period", fall_log[k] - fall_log[k-1], 300);
        interval = '0;
        nf = n_falls;
        step(700);
        check("t2_no_read", n_falls - nf, 0);

        // 3: overrun, clear, and set-wins-over-clear
        sample_ready = 1'b0;
        preset = 16'h041F;
        pulse_req();
        wait_cs(1'b0, 10, "t3_a_start");
        wait_cs(1'b1, 200, "t3_a_end");
        check("t3_no_ovr", overrun, 0);
        preset = 16'h0A5F;
        pulse_req();
        wait_cs(1'b0, 30, "t3_b_start");
        wait_cs(1'b1, 200, "t3_b_end");
        check("t3_ovr_set", overrun, 1);
        check("t3_data2", sample_data, 16'h0A5F);
        clr_overrun = 1'b1;
        step(1);
        clr_overrun = 1'b0;
        exp_ovr = 1'b0;
        check("t3_ovr_clr", overrun, 0);
        clr_overrun = 1'b1;
        preset = 16'h0C3F;
        pulse_req();
        wait_cs(1'b0, 30, "t3_c_start");
        wait_cs(1'b1, 200, "t3_c_end");
        check("t3_set_wins", overrun, 1);
        clr_overrun = 1'b0;
        step(1);
        check("t3_ovr_hold", overrun, 1);
        sample_ready = 1'b1;
        step(2);
        clr_overrun = 1'b1;
        step(1);
        clr_overrun = 1'b0;
        exp_ovr = 1'b0;

        // 4: three reqs during a transfer coalesce into one follow-up
        preset = 16'h041F;
        nf = n_falls;
        pulse_req();
        wait_cs(1'b0, 10, "t4_start");
        step(20);
        pulse_req();
        step(30);
        pulse_req();
        step(30);
        pulse_req();
        wait_cs(1'b1, 200, "t4_end1");
        wait_cs(1'b0, 40, "t4_second");
        check("t4_gap_ge", (fall_cyc - rise_cyc) >= CS_IDLE, 1);
        wait_cs(1'b1, 200, "t4_end2");
        step(400);
        check("t4_count", n_falls - nf, 2);

        // 5: reset in mid-frame discards it
        sample_ready = 1'b0;
        preset = 16'h041F;
        pulse_req();
        wait_cs(1'b0, 10, "t5_start");
        n = 0;
        while (rises < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_rise7", rises, 7);
        rst = 1'b1;
        model_reset();
        step(1);
        check("t5_cs_n", cs_n, 1);
        check("t5_sck", sck, 0);
        check("t5_valid", sample_valid, 0);
        check("t5_busy", busy, 0);
        rst = 1'b0;
        step(2);
        sample_ready = 1'b1;
        pulse_req();
        wait_cs(1'b0, 10, "t5_re_start");
        wait_cs(1'b1, 200, "t5_re_end");
        check("t5_data", sample_data, 16'h041F);
        step(3);

`ifdef LM07_AVG4_EN
        // 6: running mean of the last four loads
        apply_reset();
        sample_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            preset = (k < 2) ? 16'h041F : 16'h081F;
            pulse_req();
            wait_cs(1'b0, 30, "t6_start");
            wait_cs(1'b1, 200, "t6_end");
        end
        check("t6_avg", temp_q, 48);
        step(3);
`endif

        // Randomised phase
        apply_reset();
        rand_frames = 1'b1;
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            en           = ($urandom_range(0, 15) != 0);
            req          = ($urandom_range(0, 299) == 0);
            sample_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2999) == 0) begin
                case ($urandom_range(0, 4))
                    0:       interval = '0;
                    1:       interval = 16'd1;
                    2:       interval = 16'd160;
                    3:       interval = 16'($urandom_range(100, 600));
                    default: interval = 16'd250;
                endcase
            end
        end
        en = 1'b0;
        req = 1'b0;
        interval = '0;
        n = 0;
        while ((busy || cs_n !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", busy, 0);
        sample_ready = 1'b1;
        step(3);
        check("drain_empty", exp_q.size(), 0);
        check("final_overrun", overrun, exp_ovr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lm07_read_sched.md
Name: lm07_read_sched

Overview:
Sequences SPI reads of the LM07/LM70-family temperature sensor.
- Drives CS and SCK, captures the 16-bit SIO frame and presents it on a valid/ready output.
- Arbitrates two read sources: a periodic interval timer and a single-shot request pulse. Pending demands from both are merged into one transfer.
- Sits between the sensor pins and the display/formatting logic.

Parameters:
- CLK_DIV, 4: SCK half-period in clk cycles; allowed range ≥1.
- CS_SETUP, 4: clk cycles from cs_n falling to the first SCK rise.
- CS_IDLE, 8: minimum clk cycles cs_n stays high between transfers.
- PERIOD_W, 16: width of the interval counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  block enable; 0 suppresses new transfers, and an active transfer completes normally.
- interval  in  PERIOD_W  periodic read interval in clk cycles; 0 disables periodic reads.
- req  in  1  single-shot read request, one-cycle pulse.
- busy  out  1  high while a transfer is in progress (any state except IDLE or GAP).
- cs_n  out  1  sensor chip select, active-low.
- sck  out  1  sensor serial clock; idles low.
- sio  in  1  sensor serial data, already synchronised externally.
- sample_valid  out  1  output holds an unconsumed sample.
- sample_ready  in  1  consumer accepts the sample.
- sample_data  out  16  raw frame, MSB first.
- temp_q  out  11  signed temperature, sample_data[15:5], 0.25 °C/LSB.
- overrun  out  1  sticky: an unconsumed sample was overwritten.
- clr_overrun  in  1  clears overrun.

Behaviour:
Reset values:
- cs_n=1, sck=0, busy=0, sample_valid=0, sample_data=0, overrun=0.
- FSM=IDLE; interval counter=0; pending=0.

Request arbitration:
- The periodic tick fires when the interval counter reaches interval-1. The counter then wraps to 0 and counts only while en=1 and interval≠0.
- A change of interval restarts the counter at 0.
- A tick or a req pulse sets pending. Multiple demands arriving before a transfer starts coalesce into one transfer.
- pending clears on the IDLE→SETUP transition.
- A demand arriving during a transfer sets pending for the next transfer.

FSM states and transitions:
- IDLE: pending && en → SETUP, and cs_n drops the same edge.
- SETUP: wait CS_SETUP cycles → SCK_HI, with sck=1.
- SCK_HI: hold CLK_DIV cycles. On the last cycle, sio shifts into the LSB of the shift register. Then → SCK_LO with sck=0.
- SCK_LO: hold CLK_DIV cycles. Go → SCK_HI if bit_cnt<15, else → DONE.
- DONE: one cycle. cs_n=1; load the output register; bit_cnt=0 → GAP.
- GAP: cs_n high for CS_IDLE cycles → IDLE.

Timing and data:
- Exactly 16 SCK rising edges occur per cs_n-low window.
- The sensor shifts on the SCK falling edge, so sio is stable throughout SCK_HI.
- Transfer length, cs_n fall to cs_n rise: CS_SETUP + 32·CLK_DIV + 1 cycles.

Output handshake:
- A transfer occurs when sample_valid && sample_ready at a clk edge; sample_valid clears the next cycle unless DONE loads in the same cycle.
- In DONE: if sample_valid=1 and sample_ready=0, the new sample overwrites the old one and overrun is set. DONE with a simultaneous accept is not an overrun.
- sample_data and temp_q change only on a DONE load.

Boundary cases:
- clr_overrun and a simultaneous overrun: set wins.
- rst mid-transfer: next edge gives cs_n=1, sck=0, and the partial frame is discarded.
- en falling mid-transfer: the transfer completes and pending is retained.
- interval=1: a tick every cycle. Reads then run back-to-back, limited by GAP.

Optional Feature:
LM07_AVG4_EN
- Defined: temp_q carries the arithmetic mean of the last 4 loaded temp_q values, using a signed 13-bit sum with an arithmetic shift right by 2 (truncation toward −inf).
- Before 4 samples are loaded, the history is pre-filled with the first sample.
- The history clears on rst. sample_data stays raw.
- Undefined: temp_q is sample_data[15:5] directly.

Decomposition:
- Package lm07_pkg holds:
  - FSM state enum: IDLE, SETUP, SCK_HI, SCK_LO, DONE, GAP.
  - LM07_FRAME_BITS=16, LM07_TEMP_MSB=15, LM07_TEMP_LSB=5, LM07_TEMP_W=11.
- One sub-module, lm07_interval_timer: interval counter plus tick generation, with restart on interval change.

Test Plan:
1. Sensor model preset 0x041F, req pulse, CLK_DIV=4, CS_SETUP=4:
   - 16 sck rises while cs_n=0.
   - cs_n low for 133 cycles.
   - sample_valid=1 with sample_data=0x041F and temp_q=32 (8 °C).
2. Preset 0x101F, interval=300, sample_ready=1:
   - cs_n falls every 300 cycles.
   - Each read gives temp_q=128.
   - No read occurs when interval=0.
3. Two reads with sample_ready=0:
   - Second DONE sets overrun=1 and sample_data shows the second frame.
   - clr_overrun → 0.
   - A simultaneous overrun and clr_overrun leaves overrun=1.
4. req pulses 3 times during one transfer: exactly one extra transfer follows, after a GAP of ≥8 cycles.
5. rst asserted at the 7th sck rise:
   - Next cycle cs_n=1, sck=0, sample_valid=0.
   - A later req reads the full 0x041F correctly.
6. With LM07_AVG4_EN, frames 0x041F, 0x041F, 0x081F, 0x081F: final temp_q=48.
